// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
//   Bundles the two handshakes of the fetch stage:
//     - instruction memory side : imem_req / imem_addr / imem_ack / imem_rdata
//     - decode side             : instr / instr_valid / decode_ready /
//                                 redirect / redirect_target
//   Modports:
//     master : the fetch unit (drives req/addr/instr/instr_valid)
//     slave  : the environment (memory + decoder)
//
//   Handshake semantics:
//     A memory transfer happens on a rising edge where imem_req=1 and
//     imem_ack=1; imem_rdata is captured on that edge. imem_req and
//     imem_addr stay stable until that edge.
//     A decode transfer happens on a rising edge where instr_valid=1 and
//     decode_ready=1; redirect/redirect_target are sampled only on that edge.
//     instr stays stable while instr_valid=1 and decode_ready=0.
// ---------------------------------------------------------------------------
interface instr_fetch_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_rdata;
  logic [WIDTH-1:0] instr;
  logic             instr_valid;
  logic             decode_ready;
  logic             redirect;
  logic [WIDTH-1:0] redirect_target;

  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_ack, imem_rdata, decode_ready, redirect, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_ack, imem_rdata, decode_ready, redirect, redirect_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage ahead of the decoder. Holds the PC, requests one word at a
//   time from instruction memory, buffers it (single entry) until decode
//   accepts it, then advances the PC by 4 or to the redirect target returned
//   with the accept. A redirect to a non-word-aligned target halts fetching
//   and raises a sticky fault until reset.
//
//   Ports:
//     clk, rst      : clock (rising edge), asynchronous active-high reset
//     bus (master)  : memory and decode handshakes, see instr_fetch_if
//     pc            : address of the current fetch / presented instruction
//     pc_plus4      : pc + 4 (wraps), link value for jumps
//     fetch_fault   : sticky misaligned-redirect flag
//     instr_count   : instructions accepted by decode (wraps)
//     dbg_state     : current FSM state (IDLE=0, REQ=1, HOLD=2, HALT=3)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  instr_fetch_if.master    bus,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             fetch_fault,
  output logic [31:0]      instr_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_instr;
  logic             r_instr_valid;
  logic             r_fetch_fault;
  logic [31:0]      r_instr_count;
  logic [WIDTH-1:0] w_pc_plus4;

  // Natural modulo-2^WIDTH wrap; a wrap past the top is not a fault.
  assign w_pc_plus4 = r_pc + WIDTH'(4);

  assign bus.imem_req    = (r_state == S_REQ);
  assign bus.imem_addr   = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_instr_valid;
  assign pc              = r_pc;
  assign pc_plus4        = w_pc_plus4;
  assign fetch_fault     = r_fetch_fault;
  assign instr_count     = r_instr_count;
  assign dbg_state       = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_fetch_fault <= 1'b0;
      r_instr_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;

        // Wait for memory as long as it takes; pc (and thus imem_addr) is held.
        S_REQ: begin
          if (bus.imem_ack) begin
            r_instr       <= bus.imem_rdata;
            r_instr_valid <= 1'b1;
            r_state       <= S_HOLD;
          end
        end

        // Single-entry buffer: no new fetch until decode takes this word.
        S_HOLD: begin
          if (bus.decode_ready) begin
            r_instr_valid <= 1'b0;
            r_instr_count <= r_instr_count + 32'd1;
            if (!bus.redirect) begin
              r_pc    <= w_pc_plus4;
              r_state <= S_REQ;
            end else if (bus.redirect_target[1:0] == 2'b00) begin
              r_pc    <= bus.redirect_target;
              r_state <= S_REQ;
            end else begin
              // Misaligned target: keep the pc of the offending instruction.
              r_fetch_fault <= 1'b1;
              r_state       <= S_HALT;
            end
          end
        end

        S_HALT: r_state <= S_HALT;

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit. Drivers act 1 time unit after the
//   rising edge; the monitor samples on the falling edge. Each acked memory
//   word is pushed with its address into the expected queues and popped by
//   the monitor when decode accepts it. A second instance with
//   RESET_PC=0xFFFF_FFFC covers the pc wrap.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_pc_q[$];

  // ---------------- DUT 1: RESET_PC = 0 ----------------
  instr_fetch_if #(.WIDTH(W)) bus ();
  logic [W-1:0] d1_pc, d1_pc_plus4;
  logic         d1_fault;
  logic [31:0]  d1_count;
  logic [1:0]   d1_state;

  instr_fetch_unit #(.WIDTH(W), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.master),
    .pc          (d1_pc),
    .pc_plus4    (d1_pc_plus4),
    .fetch_fault (d1_fault),
    .instr_count (d1_count),
    .dbg_state   (d1_state)
  );

  // ---------------- DUT 2: RESET_PC = 0xFFFF_FFFC ----------------
  instr_fetch_if #(.WIDTH(W)) bus2 ();
  logic [W-1:0] d2_pc, d2_pc_plus4;
  logic         d2_fault;
  logic [31:0]  d2_count;
  logic [1:0]   d2_state;

  instr_fetch_unit #(.WIDTH(W), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus2.master),
    .pc          (d2_pc),
    .pc_plus4    (d2_pc_plus4),
    .fetch_fault (d2_fault),
    .instr_count (d2_count),
    .dbg_state   (d2_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h @%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: an accept is in progress when valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && bus.instr_valid && bus.decode_ready) begin
      if (exp_q.size() == 0) begin
        check("accept_unexpected_instr", bus.instr, 32'hDEAD_BEEF);
      end else begin
        logic [W-1:0] e_i, e_p;
        e_i = exp_q.pop_front();
        e_p = exp_pc_q.pop_front();
        check("accept_instr", bus.instr, e_i);
        check("accept_pc", d1_pc, e_p);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_for_req();
    int n = 0;
    while (!bus.imem_req && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("req_seen", bus.imem_req, 1);
  endtask

  // Hold ack low for 'stall' cycles (address must stay put), then ack.
  task automatic do_fetch(input logic [W-1:0] data, input int stall, input logic [W-1:0] exp_addr);
    wait_for_req();
    check("fetch_addr", bus.imem_addr, exp_addr);
    check("valid_low_in_req", bus.instr_valid, 0);
    for (int i = 0; i < stall; i++) begin
      bus.imem_ack = 1'b0;
      @(posedge clk); #1;
      check("stall_addr_stable", bus.imem_addr, exp_addr);
      check("stall_req_held", bus.imem_req, 1);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = data;
    exp_q.push_back(data);
    exp_pc_q.push_back(exp_addr);
    @(posedge clk); #1;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    check("hold_valid", bus.instr_valid, 1);
    check("hold_req_low", bus.imem_req, 0);
  endtask

  // Stall decode 'stall' cycles with a bogus redirect asserted, then accept.
  task automatic do_accept(input int stall, input logic redir, input logic [W-1:0] tgt,
                           input logic [W-1:0] e_instr, input logic [W-1:0] e_pc,
                           input logic [31:0] e_cnt);
    for (int i = 0; i < stall; i++) begin
      bus.decode_ready    = 1'b0;
      bus.redirect        = 1'b1;
      bus.redirect_target = 32'h0000_0080;
      @(posedge clk); #1;
      check("stall_instr", bus.instr, e_instr);
      check("stall_pc", d1_pc, e_pc);
      check("stall_count", d1_count, e_cnt);
      check("stall_valid", bus.instr_valid, 1);
    end
    bus.decode_ready    = 1'b1;
    bus.redirect        = redir;
    bus.redirect_target = tgt;
    @(posedge clk); #1;
    bus.decode_ready    = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_target = '0;
  endtask

  // Assert reset between clock edges and verify reset values right away.
  task automatic async_reset();
    #3 rst = 1'b1;
    #1;
    exp_q.delete();
    exp_pc_q.delete();
    check("rst_req", bus.imem_req, 0);
    check("rst_pc", d1_pc, 32'h0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_valid", bus.instr_valid, 0);
    check("rst_fault", d1_fault, 0);
    check("rst_count", d1_count, 0);
    check("rst_state", d1_state, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.imem_ack = 1'b0;  bus.imem_rdata = '0;
    bus.decode_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_target = '0;
    bus2.imem_ack = 1'b0; bus2.imem_rdata = '0;
    bus2.decode_ready = 1'b0; bus2.redirect = 1'b0; bus2.redirect_target = '0;

    #1 rst = 1'b1;
    #1;
    check("init_req", bus.imem_req, 0);
    check("init_pc", d1_pc, 32'h0);
    check("init_valid", bus.instr_valid, 0);
    check("init_count", d1_count, 0);
    check("init_fault", d1_fault, 0);
    check("init_state", d1_state, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1. Back-to-back fetches, sequential pc
    do_fetch(32'h0000_0013, 0, 32'h0);
    do_accept(0, 1'b0, '0, 32'h0000_0013, 32'h0, 0);
    do_fetch(32'h0010_0113, 0, 32'h4);
    do_accept(0, 1'b0, '0, 32'h0010_0113, 32'h4, 1);
    do_fetch(32'h0020_0193, 0, 32'h8);
    do_accept(0, 1'b0, '0, 32'h0020_0193, 32'h8, 2);
    check("t1_count", d1_count, 3);
    check("t1_pc", d1_pc, 32'hC);

    // 2. Memory wait at pc=0xC (pc now 0xC after three sequential accepts)
    do_fetch(32'h0050_0093, 5, 32'hC);
    check("t2_instr", bus.instr, 32'h0050_0093);

    // 3. Decode stall with redirect ignored, then taken redirect to 0x40
    do_accept(4, 1'b1, 32'h0000_0040, 32'h0050_0093, 32'hC, 3);
    check("t3_pc", d1_pc, 32'h40);
    check("t3_addr", bus.imem_addr, 32'h40);
    check("t3_pc_plus4", d1_pc_plus4, 32'h44);
    check("t3_count", d1_count, 4);
    check("t3_req", bus.imem_req, 1);

    // 4. Misaligned redirect -> HALT
    do_fetch(32'h0420_006F, 0, 32'h40);
    do_accept(0, 1'b1, 32'h0000_0042, 32'h0420_006F, 32'h40, 4);
    check("t4_fault", d1_fault, 1);
    check("t4_valid", bus.instr_valid, 0);
    check("t4_pc", d1_pc, 32'h40);
    check("t4_count", d1_count, 5);
    check("t4_state", d1_state, 3);
    for (int i = 0; i < 3; i++) begin
      bus.imem_ack = 1'b1;
      bus.decode_ready = 1'b1;
      @(posedge clk); #1;
      check("t4_req_stays_low", bus.imem_req, 0);
      check("t4_fault_sticky", d1_fault, 1);
    end
    bus.imem_ack = 1'b0;
    bus.decode_ready = 1'b0;

    // 6a. Reset out of HALT, then async reset mid-REQ
    async_reset();
    wait_for_req();
    check("t6_addr_after_halt", bus.imem_addr, 32'h0);
    async_reset();

    // 6b. Fetch, then reset mid-HOLD
    do_fetch(32'h1111_1111, 0, 32'h0);
    async_reset();
    do_fetch(32'h2222_2222, 2, 32'h0);
    do_accept(0, 1'b0, '0, 32'h2222_2222, 32'h0, 0);
    check("t6_count", d1_count, 1);
    check("t6_pc", d1_pc, 32'h4);

    // 5. Second instance: pc wrap from 0xFFFF_FFFC
    check("t5_addr", bus2.imem_addr, 32'hFFFF_FFFC);
    check("t5_req", bus2.imem_req, 1);
    check("t5_pc_plus4", d2_pc_plus4, 32'h0);
    bus2.imem_ack = 1'b1;
    bus2.imem_rdata = 32'hABCD_0013;
    @(posedge clk); #1;
    bus2.imem_ack = 1'b0;
    check("t5_instr", bus2.instr, 32'hABCD_0013);
    check("t5_valid", bus2.instr_valid, 1);
    bus2.decode_ready = 1'b1;
    bus2.redirect = 1'b0;
    @(posedge clk); #1;
    bus2.decode_ready = 1'b0;
    check("t5_pc_wrap", d2_pc, 32'h0);
    check("t5_fault", d2_fault, 0);
    check("t5_addr_wrap", bus2.imem_addr, 32'h0);
    check("t5_count", d2_count, 1);

    @(posedge clk); #1;
    check("sb_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
